// File: rtl/legv8_enc_pkg.sv
// Shared LEGv8 encoding definitions: format codes, field geometry, opcodes, helpers.
package legv8_enc_pkg;

  typedef enum logic [1:0] {
    FMT_B   = 2'd0,
    FMT_D   = 2'd1,
    FMT_CB  = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned IMM_W    = 64;
  localparam int unsigned OPC_W    = 11;
  localparam int unsigned REG_W    = 5;

  // Immediate field widths and the widest one, which sizes the stage-1 field store
  localparam int unsigned IMM_W_B  = 26;
  localparam int unsigned IMM_W_D  = 9;
  localparam int unsigned IMM_W_CB = 19;
  localparam int unsigned FIELD_W  = IMM_W_B;

  // Opcode widths (opcodes arrive left-justified in OPC_W bits)
  localparam int unsigned OPC_W_B  = 6;
  localparam int unsigned OPC_W_CB = 8;

  // Bit positions inside the instruction word
  localparam int unsigned OPC_LSB_B  = 26;
  localparam int unsigned OPC_LSB_D  = 21;
  localparam int unsigned OPC_LSB_CB = 24;
  localparam int unsigned IMM_LSB_B  = 0;
  localparam int unsigned IMM_LSB_D  = 12;
  localparam int unsigned IMM_LSB_CB = 5;
  localparam int unsigned RN_LSB_D   = 5;
  localparam int unsigned RT_LSB     = 0;

  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [7:0]  OPC_CBNZ = 8'hB5;

  // Stage-1 payload: everything needed to assemble the word one cycle later
  typedef struct packed {
    fmt_e               fmt;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rt;
    logic [FIELD_W-1:0] field;
    logic               fits;
  } s1_t;

  // True when imm survives truncation to w bits followed by sign extension
  function automatic logic sext_fits(input logic [IMM_W-1:0] imm, input int unsigned w);
    logic [IMM_W-1:0] hi;
    hi = IMM_W'($signed(imm) >>> (w - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  // Assemble the instruction word from a stage-1 payload; reserved format yields zero
  function automatic logic [INST_W-1:0] pack_inst(input s1_t s);
    logic [INST_W-1:0] w;
    w = '0;
    case (s.fmt)
      FMT_B: begin
        w = (INST_W'(s.opcode[OPC_W-1 -: OPC_W_B]) << OPC_LSB_B)
          | (INST_W'(s.field[IMM_W_B-1:0]) << IMM_LSB_B);
      end
      FMT_D: begin
        w = (INST_W'(s.opcode) << OPC_LSB_D)
          | (INST_W'(s.field[IMM_W_D-1:0]) << IMM_LSB_D)
          | (INST_W'(s.rn) << RN_LSB_D)
          | (INST_W'(s.rt) << RT_LSB);
      end
      FMT_CB: begin
        w = (INST_W'(s.opcode[OPC_W-1 -: OPC_W_CB]) << OPC_LSB_CB)
          | (INST_W'(s.field[IMM_W_CB-1:0]) << IMM_LSB_CB)
          | (INST_W'(s.rt) << RT_LSB);
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational range check and truncation of a signed immediate for a given format.
module imm_fit_check
  import legv8_enc_pkg::*;
(
  input  logic [IMM_W-1:0]   imm,
  input  fmt_e               fmt,
  output logic               fits_c,
  output logic [FIELD_W-1:0] field_c
);

  // Select field width by format; reserved format never fits
  always_comb begin
    fits_c  = 1'b0;
    field_c = '0;
    case (fmt)
      FMT_B: begin
        fits_c  = sext_fits(imm, IMM_W_B);
        field_c = FIELD_W'(imm[IMM_W_B-1:0]);
      end
      FMT_D: begin
        fits_c  = sext_fits(imm, IMM_W_D);
        field_c = FIELD_W'(imm[IMM_W_D-1:0]);
      end
      FMT_CB: begin
        fits_c  = sext_fits(imm, IMM_W_CB);
        field_c = FIELD_W'(imm[IMM_W_CB-1:0]);
      end
      default: begin
        fits_c  = 1'b0;
        field_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/inst_imm_encoder.sv
// Two-stage elastic LEGv8 B/D/CB instruction encoder with range flagging and error count.
module inst_imm_encoder
  import legv8_enc_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 Reset_L,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_fmt,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [REG_W-1:0]     in_rn,
  input  logic [REG_W-1:0]     in_rt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INST_W-1:0]    out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic               s1_valid;
  s1_t                s1_q;
  logic               fit_fits_c;
  logic [FIELD_W-1:0] fit_field_c;
  logic               s2_load_c;
  logic               s1_adv_c;
  logic               in_fire_c;

  imm_fit_check u_fit (
    .imm     (in_imm),
    .fmt     (fmt_e'(in_fmt)),
    .fits_c  (fit_fits_c),
    .field_c (fit_field_c)
  );

  // Handshake plumbing; in_ready is held low while reset is asserted
  assign s2_load_c = !out_valid || out_ready;
  assign s1_adv_c  = s1_valid && s2_load_c;
  assign in_ready  = Reset_L && (!s1_valid || s1_adv_c);
  assign in_fire_c = in_valid && in_ready;

  // Stage 1: capture request fields, truncated immediate and range verdict
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire_c) begin
      s1_valid    <= 1'b1;
      s1_q.fmt    <= fmt_e'(in_fmt);
      s1_q.opcode <= in_opcode;
      s1_q.rn     <= in_rn;
      s1_q.rt     <= in_rt;
      s1_q.field  <= fit_field_c;
      s1_q.fits   <= fit_fits_c;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: assemble word; held stable while stalled downstream
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= pack_inst(s1_q);
        out_err  <= !s1_q.fits;
      end
    end
  end

  // Saturating count of errored words actually delivered
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
